// File: rtl/phy_rx_pkg.sv
// Shared types and constants for the two-lane PHY receive controller.
// State encoding, default framing symbol and packed-word byte positions.
package phy_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;

  // Bit offset of each lane byte within the 32-bit packed word.
  localparam int LANE0_HI_LSB = 24;
  localparam int LANE1_HI_LSB = 16;
  localparam int LANE0_LO_LSB = 8;
  localparam int LANE1_LO_LSB = 0;

endpackage

// File: rtl/phy_rx_lane_pack.sv
// Two-phase byte packer: phase 0 captures the upper half, phase 1 emits the word.
// A clear discards any captured upper half and suppresses output.
module phy_rx_lane_pack
  import phy_rx_pkg::*;
(
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        phase,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  lane0,
  input  logic [7:0]  lane1,
  output logic [31:0] data_out,
  output logic        valid_out
);

  logic [7:0]  hi_lane0;
  logic [7:0]  hi_lane1;
  logic [31:0] word_next;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    word_next                      = '0;
    word_next[LANE0_HI_LSB +: 8]   = hi_lane0;
    word_next[LANE1_HI_LSB +: 8]   = hi_lane1;
    word_next[LANE0_LO_LSB +: 8]   = lane0;
    word_next[LANE1_LO_LSB +: 8]   = lane1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      hi_lane0  <= '0;
      hi_lane1  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (clear) begin
        hi_lane0 <= '0;
        hi_lane1 <= '0;
      end else if (load) begin
        if (!phase) begin
          hi_lane0 <= lane0;
          hi_lane1 <= lane1;
        end else begin
          data_out  <= word_next;
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phy_rx_lane_ctrl.sv
// RX lane controller: COM-pair symbol lock, fault detection and lane unstriping.
// Optional loss-of-COM watchdog enabled by defining PHY_RX_LOSS_WATCHDOG_EN.
module phy_rx_lane_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM_SYM    = COM_SYM_DEFAULT,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_LIMIT = 64
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  data_in_0,
  input  logic        valid_in_0,
  input  logic [7:0]  data_in_1,
  input  logic        valid_in_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        locked,
  output logic        error
);

  if (LOCK_COUNT < 1 || LOCK_COUNT > 15 || LOSS_LIMIT < 1) begin : g_param_check
    $error("phy_rx_lane_ctrl: LOCK_COUNT or LOSS_LIMIT out of range");
  end

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  state_t     state;
  logic [3:0] com_cnt;
  logic       phase;

  logic       pair;
  logic       both_idle;
  logic       com_pair;
  logic       one_com;
  logic       fault;
  logic       lock_hit;
  logic       wd_fire;
  logic       pack_load;
  logic       pack_clear;
  logic [3:0] com_cnt_inc;

  always_comb begin
    pair        = valid_in_0 & valid_in_1;
    both_idle   = ~valid_in_0 & ~valid_in_1;
    com_pair    = pair & (data_in_0 == COM_SYM) & (data_in_1 == COM_SYM);
    one_com     = pair & ((data_in_0 == COM_SYM) ^ (data_in_1 == COM_SYM));
    fault       = (valid_in_0 != valid_in_1) | one_com;
    com_cnt_inc = com_cnt + 4'd1;
    lock_hit    = com_pair & (com_cnt_inc == LOCK_CNT4);
  end

`ifdef PHY_RX_LOSS_WATCHDOG_EN
  localparam int              WD_W     = $clog2(LOSS_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(LOSS_LIMIT);

  logic [WD_W-1:0] wd_cnt;

  always_comb begin
    wd_fire = (state == ACTIVE) & ~fault & ~com_pair & ((wd_cnt + WD_W'(1)) == WD_LIMIT);
  end

  // Held at zero outside ACTIVE, so entering ACTIVE starts a fresh count.
  always_ff @(posedge clk_32f) begin
    if (reset || state != ACTIVE || com_pair || wd_fire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  always_comb begin
    wd_fire = 1'b0;
  end
`endif

  always_comb begin
    pack_clear = (state == ACTIVE) & (fault | wd_fire | com_pair);
    pack_load  = (state == ACTIVE) & pair & ~com_pair & ~one_com & ~wd_fire;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state   <= IDLE;
      com_cnt <= '0;
      phase   <= 1'b0;
      locked  <= 1'b0;
      error   <= 1'b0;
    end else begin
      error <= 1'b0;
      unique case (state)
        IDLE, SEARCH: begin
          if (com_pair) begin
            if (lock_hit) begin
              state   <= ACTIVE;
              locked  <= 1'b1;
              com_cnt <= '0;
              phase   <= 1'b0;
            end else begin
              state   <= SEARCH;
              com_cnt <= com_cnt_inc;
            end
          end else begin
            com_cnt <= '0;
            if (pair)           state <= SEARCH;
            else if (both_idle) state <= IDLE;
          end
        end
        ACTIVE: begin
          if (fault || wd_fire) begin
            state   <= SEARCH;
            locked  <= 1'b0;
            error   <= 1'b1;
            com_cnt <= '0;
            phase   <= 1'b0;
          end else if (com_pair) begin
            // A COM pair mid-word means lane alignment slipped.
            error <= phase;
            phase <= 1'b0;
          end else if (pair) begin
            phase <= ~phase;
          end
        end
        default: begin
          state   <= IDLE;
          locked  <= 1'b0;
          com_cnt <= '0;
          phase   <= 1'b0;
        end
      endcase
    end
  end

  phy_rx_lane_pack u_pack (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .phase     (phase),
    .load      (pack_load),
    .clear     (pack_clear),
    .lane0     (data_in_0),
    .lane1     (data_in_1),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_phy_rx_lane_ctrl.sv
// Scoreboard bench for phy_rx_lane_ctrl: directed lane vectors, queued expected words.
// Watchdog expectations follow PHY_RX_LOSS_WATCHDOG_EN with LOSS_LIMIT = 8.
module tb_phy_rx_lane_ctrl;
  import phy_rx_pkg::*;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  data_in_0 = '0;
  logic        valid_in_0 = 1'b0;
  logic [7:0]  data_in_1 = '0;
  logic        valid_in_1 = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        locked;
  logic        error;

  phy_rx_lane_ctrl #(
    .COM_SYM    (8'hBC),
    .LOCK_COUNT (4),
    .LOSS_LIMIT (8)
  ) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in_0  (data_in_0),
    .valid_in_0 (valid_in_0),
    .data_in_1  (data_in_1),
    .valid_in_1 (valid_in_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .locked     (locked),
    .error      (error)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   err_seen = 0;
  int   exp_err  = 0;

  always @(posedge clk_32f) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a word is presented, counts error pulses.
  always @(negedge clk_32f) begin
    if (error === 1'b1) err_seen++;
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h with no word expected at cycle %0d", data_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word", data_out, e.word);
        check("word_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    valid_in_0 = v0;
    data_in_0  = d0;
    valid_in_1 = v1;
    data_in_1  = d1;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic pair(input logic [7:0] d0, input logic [7:0] d1);
    drive(1'b1, d0, 1'b1, d1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic com(input int n);
    for (int i = 0; i < n; i++) pair(8'hBC, 8'hBC);
  endtask

  // The word completes on the edge that samples the next pair, seen one cycle later.
  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back('{word: w, due: cyc + 1});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, data_out, 32'h0);
    check({tag, "_valid_out"}, {31'b0, valid_out}, 32'h0);
    check({tag, "_locked"}, {31'b0, locked}, 32'h0);
    check({tag, "_error"}, {31'b0, error}, 32'h0);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    logic [7:0] a0, a1, b0, b1;

    // Reset with both lanes idle
    reset = 1'b1;
    repeat (2) @(posedge clk_32f);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Acquire lock with four COM pairs
    idle(1);
    com(3);
    check("lock_after_3", {31'b0, locked}, 32'h0);
    com(1);
    check("lock_after_4", {31'b0, locked}, 32'h1);
    idle(2);
    check("err_after_lock", 32'(err_seen), 32'(exp_err));

    // Back-to-back words
    pair(8'hFF, 8'hDD);
    expect_word(32'hFFDDFFDD);
    pair(8'hFF, 8'hDD);
    pair(8'hEE, 8'hAA);
    expect_word(32'hEEAAEEAA);
    pair(8'hEE, 8'hAA);
    idle(2);
    check("err_after_words", 32'(err_seen), 32'(exp_err));

    // Gap in the middle of a word
    pair(8'hDD, 8'hFF);
    idle(3);
    expect_word(32'hDDFFAABB);
    pair(8'hAA, 8'hBB);
    idle(2);
    check("err_after_gap", 32'(err_seen), 32'(exp_err));

    // COM pair arriving mid-word
    pair(8'hCA, 8'hBF);
    com(1);
    exp_err++;
    idle(2);
    check("err_com_midword", 32'(err_seen), 32'(exp_err));
    check("locked_com_midword", {31'b0, locked}, 32'h1);
    pair(8'h11, 8'h22);
    expect_word(32'h11223344);
    pair(8'h33, 8'h44);
    idle(2);

    // Lane valid mismatch drops lock
    drive(1'b1, 8'h55, 1'b0, 8'h00);
    exp_err++;
    check("locked_after_fault", {31'b0, locked}, 32'h0);
    idle(2);
    check("err_after_fault", 32'(err_seen), 32'(exp_err));
    com(3);
    check("relock_after_3", {31'b0, locked}, 32'h0);
    com(1);
    check("relock_after_4", {31'b0, locked}, 32'h1);

    // Reset in the middle of a word
    pair(8'h66, 8'h77);
    reset = 1'b1;
    idle(1);
    check_reset_outputs("midreset");
    reset = 1'b0;
    idle(1);
    com(4);
    check("lock_after_reset", {31'b0, locked}, 32'h1);
    pair(8'h12, 8'h34);
    expect_word(32'h12345678);
    pair(8'h56, 8'h78);
    idle(2);
    check("err_after_reset", 32'(err_seen), 32'(exp_err));

    // Data-only stream after a fresh COM pair
    com(1);
`ifdef PHY_RX_LOSS_WATCHDOG_EN
    for (int i = 0; i < 8; i++) begin
      if (i[0] && i < 6) begin
        a0 = 8'h10 + 8'(i - 1); a1 = 8'h20 + 8'(i - 1);
        b0 = 8'h10 + 8'(i);     b1 = 8'h20 + 8'(i);
        expect_word({a0, a1, b0, b1});
      end
      pair(8'h10 + 8'(i), 8'h20 + 8'(i));
    end
    exp_err++;
    check("locked_after_watchdog", {31'b0, locked}, 32'h0);
    idle(2);
    check("err_after_watchdog", 32'(err_seen), 32'(exp_err));
`else
    for (int i = 0; i < 10; i++) begin
      if (i[0]) begin
        a0 = 8'h10 + 8'(i - 1); a1 = 8'h20 + 8'(i - 1);
        b0 = 8'h10 + 8'(i);     b1 = 8'h20 + 8'(i);
        expect_word({a0, a1, b0, b1});
      end
      pair(8'h10 + 8'(i), 8'h20 + 8'(i));
    end
    check("locked_no_watchdog", {31'b0, locked}, 32'h1);
    idle(2);
    check("err_no_watchdog", 32'(err_seen), 32'(exp_err));
`endif

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phy_rx_lane_ctrl.md
# phy_rx_lane_ctrl

Receive-side lane controller for the two-lane PCIe PHY. It sequences the RX datapath: it watches both 8-bit lanes for COM framing symbols, declares symbol lock once both lanes show aligned COM pairs, then unstripes lane bytes into 32-bit words for the upper layer. It sits between the lane deserializers and the `data_out` / `valid_out` interface consumed by the link layer.

## Interface
Parameters:
- `COM_SYM`, 8'hBC, framing symbol.
- `LOCK_COUNT`, 4, consecutive aligned COM pairs required for lock (range 1..15).
- `LOSS_LIMIT`, 64, cycles without a COM pair before lock is dropped. Used only with the watchdog macro.

Ports:
- `clk_32f`  in  1  Single clock. All logic is on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `data_in_0`  in  8  Lane 0 byte.
- `valid_in_0`  in  1  Lane 0 byte valid.
- `data_in_1`  in  8  Lane 1 byte.
- `valid_in_1`  in  1  Lane 1 byte valid.
- `data_out`  out  32  Packed word.
- `valid_out`  out  1  One-cycle pulse; `data_out` is valid while it is high.
- `locked`  out  1  High in state ACTIVE.
- `error`  out  1  One-cycle pulse on a framing or lane fault.

## Operation
- A "pair" is a cycle with `valid_in_0 && valid_in_1`. A "COM pair" is a pair where both bytes equal `COM_SYM`.
- **IDLE** (reset state). Moves to SEARCH on the first pair.
- **SEARCH**
  - A 4-bit `com_cnt` increments on each COM pair and clears on any other cycle.
  - When `com_cnt` reaches `LOCK_COUNT`, moves to ACTIVE with `phase` = 0.
  - If both valids are low, returns to IDLE.
- **ACTIVE**
  - A non-COM pair is packed:
    - `phase` 0: lane0 goes to [31:24], lane1 to [23:16].
    - `phase` 1: lane0 goes to [15:8], lane1 to [7:0]; the word is registered and `valid_out` pulses.
    - `phase` toggles after each packed pair.
  - A COM pair is dropped. `phase` resets to 0, and any partial word is discarded. If the word was partial (`phase` 1), `error` pulses and the state stays ACTIVE.
  - Both valids low: a gap. State and the partial word are held.
  - Fault, which pulses `error`, discards the partial word and moves to SEARCH with `com_cnt` = 0. Either condition is a fault:
    - `valid_in_0 != valid_in_1`;
    - a pair where exactly one byte equals `COM_SYM`.
- Priority: reset first, then fault, then COM, then data.
- Reset mid-operation: the next edge forces IDLE and clears the partial word, `com_cnt`, `phase` and all outputs.

## Timing
- Reset values: `data_out` = 32'h0, `valid_out` = 0, `locked` = 0, `error` = 0.
- All outputs are registered.
- `valid_out` is high in the cycle after the edge that samples the second (`phase` 1) pair, so latency from the second pair is 1 cycle.
- `data_out` holds its last value when `valid_out` is low.
- `locked` rises 1 cycle after the edge that samples the `LOCK_COUNT`th COM pair. It falls 1 cycle after a fault or watchdog event.
- Throughput: at most one word every 2 cycles.
- `error` is high for exactly 1 cycle per event.

## Configuration
- `PHY_RX_LOSS_WATCHDOG_EN` defined:
  - In ACTIVE, a counter `ceil(log2(LOSS_LIMIT+1))` bits wide counts cycles since the last COM pair. It clears on each COM pair and on entry to ACTIVE.
  - When it reaches `LOSS_LIMIT`, the block pulses `error`, discards any partial word and moves to SEARCH.
- Undefined: no watchdog logic is present. ACTIVE is left only by reset or a fault.

## Structure
- Package `phy_rx_pkg` holds:
  - the state encoding (IDLE=2'd0, SEARCH=2'd1, ACTIVE=2'd2);
  - the default `COM_SYM` constant;
  - the packed-word byte-lane index constants.
- Sub-module `phy_rx_lane_pack`:
  - contains the two-phase byte packer;
  - inputs are `phase`, `load`, `clear` and the lane bytes;
  - outputs are `data_out` and `valid_out`.
- The state machine, counters and watchdog stay in the top module.

## Test plan
- Reset with both lanes idle, then 4 COM pairs of 8'hBC → `locked` rises 1 cycle after the 4th pair; no `error`; `valid_out` stays 0.
- Locked, then pairs (8'hFF,8'hDD), (8'hFF,8'hDD), (8'hEE,8'hAA), (8'hEE,8'hAA) → two `valid_out` pulses carrying 32'hFFDDFFDD and 32'hEEAAEEAA, each 1 cycle after its second pair.
- Locked, then pair (8'hDD,8'hFF), a 3-cycle both-invalid gap, then (8'hAA,8'hBB) → one word 32'hDDFFAABB; the gap causes no error.
- Locked, then pair (8'hCA,8'hBF) followed by a COM pair → `error` pulses once; no `valid_out`; `locked` stays 1; the next two data pairs pack from [31:24].
- Locked, then `valid_in_0`=1 with `valid_in_1`=0 → `error` pulses and `locked` falls; 4 more COM pairs are needed to relock. Asserting `reset` mid-word then releasing it → all outputs 0 and state IDLE.
- With `PHY_RX_LOSS_WATCHDOG_EN` and `LOSS_LIMIT`=8: 8 data-only cycles after lock → `error` pulses and `locked` falls. The same stimulus without the macro → `locked` stays 1.
